pack_coalesce: RTL

- Sequences the output of the N-slot packer into a valid/ready stream of full-width beats.
- Each upstream beat carries 0..N left-justified valid slots. The block merges these into a residue buffer and emits a beat only when N slots are filled or a flush arrives.
- The result is that downstream consumers see dense N-slot beats, apart from the final partial beat of each packet.
- It sits directly after the packer, with one output register stage.

---
 rtl/pack_pkg.sv | 21 ++
 rtl/pack_coalesce_chk.sv | 21 ++
 rtl/pack_merge.sv | 46 ++++
 rtl/pack_coalesce.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pack_pkg.sv
// Shared types and helpers for the pack_coalesce slice.
package pack_pkg;

   localparam int unsigned PACK_N = 8;

   // Slot count wide enough to hold 0..N (and sums up to 2N-1).
   typedef logic [$clog2(PACK_N):0] cnt_t;

   // RUN accepts upstream beats; DRAIN emits the residue left by an overflowing flush.
   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } pack_coalesce_st_t;

   // Builds the text reported when a field exceeds its legal bound.
   function automatic string pack_msg(input string what, input int unsigned val,
                                      input int unsigned lim);
      return $sformatf("pack_coalesce: %s=%0d exceeds limit %0d", what, val, lim);
   endfunction

endpackage

// File: rtl/pack_coalesce_chk.sv
// Protocol checker for the upstream side of pack_coalesce.
module pack_coalesce_chk
   import pack_pkg::*;
#(
   parameter int unsigned N = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   input logic                 in_vld,
   input logic                 in_rdy,
   input logic [$clog2(N):0]   in_cnt
);

   localparam int unsigned CW = $clog2(N) + 1;

   // An accepted beat may never claim more than N valid slots.
   a_in_cnt_legal: assert property (@(posedge clk) disable iff (!rst_n)
      (in_vld && in_rdy) |-> (in_cnt <= CW'(N)))
      else $error("%s", pack_msg("in_cnt", 32'(in_cnt), N));

endmodule

// File: rtl/pack_merge.sv
// Combinational merge of the residue buffer with an incoming beat.
// Incoming slots are placed directly after the held slots; unused slots read as zero.
module pack_merge
   import pack_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = 32
) (
   input  logic [(N-1)*W-1:0]   acc,
   input  logic [$clog2(N):0]   acc_cnt,
   input  logic [N*W-1:0]       in_w,
   input  logic [$clog2(N):0]   in_cnt,
   output logic [(2*N-1)*W-1:0] m,
   output logic [$clog2(N):0]   s
);

   localparam int unsigned CW = $clog2(N) + 1;
   localparam int unsigned MW = (2*N-1) * W;

   logic [MW-1:0] acc_ext_s;
   logic [MW-1:0] in_ext_s;

   // Zero every slot beyond its valid count so the OR below cannot pick up stale data.
   always_comb begin
      acc_ext_s = {MW{1'b0}};
      in_ext_s  = {MW{1'b0}};
      for (int i = 0; i < int'(N) - 1; i++) begin
         if (CW'(i) < acc_cnt) begin
            acc_ext_s[i*W +: W] = acc[i*W +: W];
         end else begin
            acc_ext_s[i*W +: W] = {W{1'b0}};
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (CW'(i) < in_cnt) begin
            in_ext_s[i*W +: W] = in_w[i*W +: W];
         end else begin
            in_ext_s[i*W +: W] = {W{1'b0}};
         end
      end
   end

   assign m = acc_ext_s | (in_ext_s << (32'(acc_cnt) * 32'(W)));
   assign s = acc_cnt + in_cnt;

endmodule

// File: rtl/pack_coalesce.sv
// Coalesces partially filled packer beats into dense N-slot output beats.
// Holds up to N-1 residue slots and one registered output beat.
module pack_coalesce
   import pack_pkg::*;
#(
   parameter int unsigned N = 8,
   parameter int unsigned W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [N*W-1:0]       in_w,
   input  logic [$clog2(N):0]   in_cnt,
   input  logic                 in_flush,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [N*W-1:0]       out_w,
   output logic [$clog2(N):0]   out_cnt,
   output logic                 out_last
);

   localparam int unsigned CW = $clog2(N) + 1;
   localparam int unsigned MW = (2*N-1) * W;
   localparam logic [CW-1:0] N_C = CW'(N);

   pack_coalesce_st_t  st_q, st_d;
   logic [(N-1)*W-1:0] acc_q, acc_d;
   logic [CW-1:0]      acc_cnt_q, acc_cnt_d;
   logic               out_vld_q, out_vld_d;
   logic [N*W-1:0]     out_w_q, out_w_d;
   logic [CW-1:0]      out_cnt_q, out_cnt_d;
   logic               out_last_q, out_last_d;

   logic               free_s;
   logic               accept_s;
   logic [MW-1:0]      m_s;
   logic [CW-1:0]      s_s;

   pack_merge #(.N(N), .W(W)) u_merge (
      .acc     (acc_q),
      .acc_cnt (acc_cnt_q),
      .in_w    (in_w),
      .in_cnt  (in_cnt),
      .m       (m_s),
      .s       (s_s)
   );

   pack_coalesce_chk #(.N(N)) u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_vld (in_vld),
      .in_rdy (in_rdy),
      .in_cnt (in_cnt)
   );

   // The output slot can take a new beat when empty or being drained this cycle.
   assign free_s   = ~out_vld_q | out_rdy;
   assign in_rdy   = rst_n & (st_q == RUN) & free_s;
   assign accept_s = in_vld & in_rdy;

   assign out_vld  = out_vld_q;
   assign out_w    = out_w_q;
   assign out_cnt  = out_cnt_q;
   assign out_last = out_last_q;

   // Next-state: drain residue, absorb a beat, or emit a full/flushed beat.
   always_comb begin
      st_d       = st_q;
      acc_d      = acc_q;
      acc_cnt_d  = acc_cnt_q;
      out_vld_d  = out_vld_q;
      out_w_d    = out_w_q;
      out_cnt_d  = out_cnt_q;
      out_last_d = out_last_q;
      if (free_s) begin
         out_vld_d = 1'b0;
         if (st_q == DRAIN) begin
            out_vld_d  = 1'b1;
            out_w_d    = {{W{1'b0}}, acc_q};
            out_cnt_d  = acc_cnt_q;
            out_last_d = 1'b1;
            acc_cnt_d  = {CW{1'b0}};
            st_d       = RUN;
         end else if (accept_s) begin
            if (in_flush) begin
               out_vld_d = 1'b1;
               out_w_d   = m_s[N*W-1:0];
               if (s_s <= N_C) begin
                  out_cnt_d  = s_s;
                  out_last_d = 1'b1;
                  acc_cnt_d  = {CW{1'b0}};
               end else begin
                  out_cnt_d  = N_C;
                  out_last_d = 1'b0;
                  acc_d      = m_s[MW-1:N*W];
                  acc_cnt_d  = s_s - N_C;
                  st_d       = DRAIN;
               end
            end else begin
               if (s_s < N_C) begin
                  acc_d     = m_s[(N-1)*W-1:0];
                  acc_cnt_d = s_s;
               end else begin
                  out_vld_d  = 1'b1;
                  out_w_d    = m_s[N*W-1:0];
                  out_cnt_d  = N_C;
                  out_last_d = 1'b0;
                  acc_d      = m_s[MW-1:N*W];
                  acc_cnt_d  = s_s - N_C;
               end
            end
         end else begin
            // Slot free but nothing to load: output simply goes idle.
            st_d = st_q;
         end
      end else begin
         // Downstream stalled: every field of the output register holds.
         st_d = st_q;
      end
   end

   // State, residue and output register; reset discards any held data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= RUN;
         acc_q      <= {((N-1)*W){1'b0}};
         acc_cnt_q  <= {CW{1'b0}};
         out_vld_q  <= 1'b0;
         out_w_q    <= {(N*W){1'b0}};
         out_cnt_q  <= {CW{1'b0}};
         out_last_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         acc_q      <= acc_d;
         acc_cnt_q  <= acc_cnt_d;
         out_vld_q  <= out_vld_d;
         out_w_q    <= out_w_d;
         out_cnt_q  <= out_cnt_d;
         out_last_q <= out_last_d;
      end
   end

endmodule
